// File: rtl/ysyx_220066_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between the EXU (port 0) and branch/AGU
// (port 1) paths; latches operands, registers the ALU result and returns it on valid/ready.
module ysyx_220066_alu_arb #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned CTRW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [2*XLEN-1:0] req_a_i,
    input  logic [2*XLEN-1:0] req_b_i,
    input  logic [2*CTRW-1:0] req_ctr_i,
    output logic [1:0]        resp_valid_o,
    input  logic [1:0]        resp_ready_i,
    output logic [XLEN-1:0]   resp_result_o,
    output logic              resp_zero_o,
    output logic [XLEN-1:0]   alu_a_o,
    output logic [XLEN-1:0]   alu_b_o,
    output logic [CTRW-1:0]   alu_ctr_o,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic              alu_zero_i
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [CTRW-1:0]   op_ctr_q, op_ctr_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zf_q, zf_d;
    logic              grant;

    // A lone requester wins outright; on a tie the favoured port wins.
    assign grant = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctr_d     = op_ctr_q;
        res_d        = res_q;
        zf_d         = zf_q;
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && (req_valid_i != 2'b00)) begin
                    req_ready_o = grant ? 2'b10 : 2'b01;
                    op_a_d      = grant ? req_a_i[XLEN +: XLEN] : req_a_i[0 +: XLEN];
                    op_b_d      = grant ? req_b_i[XLEN +: XLEN] : req_b_i[0 +: XLEN];
                    op_ctr_d    = grant ? req_ctr_i[CTRW +: CTRW] : req_ctr_i[0 +: CTRW];
                    owner_d     = grant;
                    prio_d      = ~grant;
                    state_d     = StExec;
                end
            end
            StExec: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    res_d   = alu_result_i;
                    zf_d    = alu_zero_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                resp_valid_o = owner_q ? 2'b10 : 2'b01;
                if (flush_i || resp_ready_i[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_ctr_q <= '0;
            res_q    <= '0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_ctr_q <= op_ctr_d;
            res_q    <= res_d;
            zf_q     <= zf_d;
        end
    end

    assign alu_a_o       = op_a_q;
    assign alu_b_o       = op_b_q;
    assign alu_ctr_o     = op_ctr_q;
    assign resp_result_o = res_q;
    assign resp_zero_o   = zf_q;

endmodule
